// File: rtl/seq_pkg.sv
// ---------------------------------------------------------------------------
// seq_pkg
//   Definitions shared by the 1011 sequence detector and the blocks that
//   consume its match pulse.
//   - win_state_e : encoding of the hit-window counter FSM (IDLE, RUN)
//   - SEQ_PATTERN : bit pattern the upstream detector matches (MSB first)
//   - SEQ_LEN     : length of that pattern in bits
// ---------------------------------------------------------------------------
package seq_pkg;

  localparam int unsigned SEQ_LEN = 4;
  localparam logic [SEQ_LEN-1:0] SEQ_PATTERN = 4'b1011;

  typedef enum logic [0:0] {
    IDLE = 1'b0,
    RUN  = 1'b1
  } win_state_e;

endpackage : seq_pkg

// File: rtl/seq_window_timer.sv
// ---------------------------------------------------------------------------
// seq_window_timer
//   Cycle counter for fixed-length counting windows. Counts 0..WINDOW_LEN-1
//   while advance_i is high and wraps straight back to 0 with no gap cycle.
//   clear_i forces the counter to 0 (a new window then starts at cycle 0).
//
//   Ports
//     clk        in   rising-edge clock
//     reset      in   synchronous, active-high reset
//     clear_i    in   restart the window (takes priority over advance_i)
//     advance_i  in   count this cycle as a window cycle
//     last_o     out  current cycle is the last of the window
// ---------------------------------------------------------------------------
module seq_window_timer
  import seq_pkg::*;
#(
  parameter int WINDOW_LEN = 16
) (
  input  logic clk,
  input  logic reset,
  input  logic clear_i,
  input  logic advance_i,
  output logic last_o
);

  localparam int WIN_W = (WINDOW_LEN > 2) ? $clog2(WINDOW_LEN) : 1;
  localparam logic [WIN_W-1:0] LAST_CNT = WIN_W'(WINDOW_LEN - 1);

  logic [WIN_W-1:0] win_cnt_q, win_cnt_d;

  assign last_o = (win_cnt_q == LAST_CNT);

  always_comb begin
    win_cnt_d = win_cnt_q;
    if (clear_i) begin
      win_cnt_d = '0;
    end else if (advance_i) begin
      win_cnt_d = last_o ? '0 : win_cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      win_cnt_q <= '0;
    end else begin
      win_cnt_q <= win_cnt_d;
    end
  end

endmodule : seq_window_timer

// File: rtl/seq_hit_window_counter.sv
// ---------------------------------------------------------------------------
// seq_hit_window_counter
//   Counts 1011-detector match pulses over fixed windows of WINDOW_LEN
//   cycles and offers each window's (saturated) total to a downstream
//   consumer. Totals that arrive while the previous one is still unaccepted
//   are dropped and recorded in the sticky overrun flag.
//
//   Optional feature macro: HIT_ALARM_EN
//     defined   : alarm is a registered one-cycle pulse on every out_count
//                 load whose value is >= THRESH
//     undefined : alarm is tied low
//
//   Ports
//     clk        in   rising-edge clock
//     reset      in   synchronous, active-high reset
//     en         in   1 = windows run, 0 = idle (partial window discarded)
//     det_in     in   match pulse from the detector
//     out_valid  out  out_count holds a completed window total
//     out_ready  in   consumer accepts out_count
//     out_count  out  hits in the completed window, saturating
//     overrun    out  sticky: a window total was dropped
//     alarm      out  threshold pulse (HIT_ALARM_EN only, else 0)
//
//   Handshake: a transfer happens on any edge where out_valid && out_ready.
//   While out_valid is high and no transfer has happened, out_count is held
//   stable. A new total may load on the same edge as a transfer.
// ---------------------------------------------------------------------------
module seq_hit_window_counter
  import seq_pkg::*;
#(
  parameter int WINDOW_LEN = 16,
  parameter int CNT_W      = 4,
  parameter int THRESH     = 3
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             en,
  input  logic             det_in,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [CNT_W-1:0] out_count,
  output logic             overrun,
  output logic             alarm
);

  if (WINDOW_LEN < 2 || CNT_W < 1 || THRESH < 0) begin : g_bad_params
    $error("seq_hit_window_counter: illegal parameter combination");
  end

  win_state_e       state_q, state_d;
  logic [CNT_W-1:0] hit_cnt_q, hit_cnt_d;
  logic             out_valid_q, out_valid_d;
  logic [CNT_W-1:0] out_count_q, out_count_d;
  logic             overrun_q, overrun_d;

  logic             run_active;
  logic             win_last;
  logic             window_end;
  logic             load_result;
  logic [CNT_W:0]   hit_sum_wide;
  logic [CNT_W-1:0] hit_sum;

  // A cycle is counted only when already in RUN and en is still high; the
  // IDLE->RUN edge itself is not a window cycle.
  assign run_active = (state_q == RUN) && en;
  assign window_end = run_active && win_last;

  seq_window_timer #(
    .WINDOW_LEN(WINDOW_LEN)
  ) u_timer (
    .clk      (clk),
    .reset    (reset),
    .clear_i  (!run_active),
    .advance_i(run_active),
    .last_o   (win_last)
  );

  // One extra bit catches the carry; on carry the count pins at all-ones.
  assign hit_sum_wide = {1'b0, hit_cnt_q} + {{CNT_W{1'b0}}, det_in};
  assign hit_sum      = hit_sum_wide[CNT_W] ? {CNT_W{1'b1}} : hit_sum_wide[CNT_W-1:0];

  // The output register is free if empty or being drained this very edge.
  assign load_result = window_end && (!out_valid_q || out_ready);

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (en)  state_d = RUN;
      RUN:     if (!en) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    hit_cnt_d   = hit_cnt_q;
    out_valid_d = out_valid_q;
    out_count_d = out_count_q;
    overrun_d   = overrun_q;

    if (!run_active || window_end) begin
      hit_cnt_d = '0;
    end else begin
      hit_cnt_d = hit_sum;
    end

    if (out_valid_q && out_ready) begin
      out_valid_d = 1'b0;
    end

    if (load_result) begin
      out_valid_d = 1'b1;
      out_count_d = hit_sum;
    end else if (window_end) begin
      overrun_d = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= IDLE;
      hit_cnt_q   <= '0;
      out_valid_q <= 1'b0;
      out_count_q <= '0;
      overrun_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      hit_cnt_q   <= hit_cnt_d;
      out_valid_q <= out_valid_d;
      out_count_q <= out_count_d;
      overrun_q   <= overrun_d;
    end
  end

  assign out_valid = out_valid_q;
  assign out_count = out_count_q;
  assign overrun   = overrun_q;

`ifdef HIT_ALARM_EN
  logic alarm_q, alarm_d;

  // Only totals that actually reach out_count can raise the alarm.
  always_comb begin
    alarm_d = load_result && (int'(hit_sum) >= THRESH);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      alarm_q <= 1'b0;
    end else begin
      alarm_q <= alarm_d;
    end
  end

  assign alarm = alarm_q;
`else
  assign alarm = 1'b0;
`endif

endmodule : seq_hit_window_counter

// File: tb/tb_seq_hit_window_counter.sv
module tb_seq_hit_window_counter;

  localparam int WINDOW_LEN = 16;
  localparam int CNT_W      = 4;
  localparam int THRESH     = 3;

`ifdef HIT_ALARM_EN
  localparam bit ALARM_ON = 1'b1;
`else
  localparam bit ALARM_ON = 1'b0;
`endif

  // ---------------- clock / reset ----------------
  logic             clk = 1'b0;
  logic             reset;
  logic             en;
  logic             det_in;
  logic             out_ready;
  logic             out_valid;
  logic [CNT_W-1:0] out_count;
  logic             overrun;
  logic             alarm;

  always #5 clk = ~clk;

  seq_hit_window_counter #(
    .WINDOW_LEN(WINDOW_LEN),
    .CNT_W     (CNT_W),
    .THRESH    (THRESH)
  ) dut (
    .clk      (clk),
    .reset    (reset),
    .en       (en),
    .det_in   (det_in),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .out_count(out_count),
    .overrun  (overrun),
    .alarm    (alarm)
  );

  // ---------------- scoreboard ----------------
  typedef struct {
    logic             en;
    logic             det;
    logic             ready;
    logic             exp_valid;
    logic [CNT_W-1:0] exp_count;   // compared only while exp_valid=1
    logic             exp_overrun;
    logic             exp_alarm;
  } vec_t;

  vec_t             vecs[$];
  logic [CNT_W-1:0] exp_q[$];
  int               checks   = 0;
  int               failures = 0;

  task automatic check_bit(input string name, input logic act, input logic exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %b expected %b (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic check_cnt(input string name, input logic [CNT_W-1:0] act,
                           input logic [CNT_W-1:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ---------------- driver ----------------
  // Inputs change 1 time unit after a rising edge; outputs are sampled at
  // the same point, i.e. they reflect the edge that just consumed the inputs.
  task automatic step(input logic e, input logic d, input logic r);
    en        = e;
    det_in    = d;
    out_ready = r;
    @(posedge clk);
    #1;
  endtask

  task automatic add_vec(input logic e, input logic d, input logic r,
                         input logic ev, input logic [CNT_W-1:0] ec,
                         input logic eo, input logic ea);
    vec_t v;
    v.en = e; v.det = d; v.ready = r;
    v.exp_valid = ev; v.exp_count = ec; v.exp_overrun = eo;
    v.exp_alarm = ALARM_ON && ea;
    vecs.push_back(v);
  endtask

  task automatic check_all_zero(input string tag);
    check_bit({tag, " out_valid"}, out_valid, 1'b0);
    check_cnt({tag, " out_count"}, out_count, '0);
    check_bit({tag, " overrun"},   overrun,   1'b0);
    check_bit({tag, " alarm"},     alarm,     1'b0);
  endtask

  // ---------------- stimulus ----------------
  initial begin
    logic [CNT_W-1:0] cur;

    // Vector table. Window k is the k-th counted cycle after IDLE->RUN.
    add_vec(1, 0, 1, 0, 0, 0, 0);                       // IDLE -> RUN
    // W1: hits on cycles 2, 5, 15 -> total 3
    for (int k = 0; k < 16; k++)
      add_vec(1, (k == 2 || k == 5 || k == 15), 1, (k == 15), 3, 0, (k == 15));
    // W2: all 16 cycles hit -> saturates at 15 (cycle 0 drains W1)
    for (int k = 0; k < 16; k++)
      add_vec(1, 1, 1, (k == 15), 15, 0, (k == 15));
    // W3: 4 more consecutive hits, consumer stalled: W2 total held, W3 dropped
    for (int k = 0; k < 16; k++)
      add_vec(1, (k < 4), 0, 1, 15, (k == 15), 0);
    // W4: one hit on last cycle; ready only on that cycle -> transfer and load
    for (int k = 0; k < 16; k++)
      add_vec(1, (k == 15), (k == 15), 1, (k == 15) ? 4'd1 : 4'd15, 1, 0);
    add_vec(1, 0, 1, 0, 0, 1, 0);                       // drain W4 total
    add_vec(0, 0, 1, 0, 0, 1, 0);                       // RUN -> IDLE

    // Reset
    reset = 1'b1; en = 1'b0; det_in = 1'b0; out_ready = 1'b0;
    step(0, 0, 0);
    step(0, 1, 1);
    check_all_zero("reset");
    reset = 1'b0;

    // Table-driven section
    foreach (vecs[i]) begin
      step(vecs[i].en, vecs[i].det, vecs[i].ready);
      check_bit($sformatf("vec%0d out_valid", i), out_valid, vecs[i].exp_valid);
      if (vecs[i].exp_valid)
        check_cnt($sformatf("vec%0d out_count", i), out_count, vecs[i].exp_count);
      check_bit($sformatf("vec%0d overrun", i), overrun, vecs[i].exp_overrun);
      check_bit($sformatf("vec%0d alarm", i), alarm, vecs[i].exp_alarm);
    end

    // en dropped at window cycle 8 after 4 hits; det ignored while idle
    step(1, 0, 1);
    for (int k = 0; k < 8; k++) begin
      step(1, (k < 4), 1);
      check_bit($sformatf("part c%0d out_valid", k), out_valid, 1'b0);
    end
    step(0, 1, 1);
    check_bit("part drop out_valid", out_valid, 1'b0);
    for (int k = 0; k < 5; k++) begin
      step(0, 1, 1);
      check_bit($sformatf("idle c%0d out_valid", k), out_valid, 1'b0);
    end
    // Re-raised: fresh window, one hit -> total 1 exactly 16 cycles later
    step(1, 0, 0);
    for (int k = 0; k < 16; k++) begin
      step(1, (k == 0), 0);
      check_bit($sformatf("restart c%0d out_valid", k), out_valid, (k == 15));
    end
    check_cnt("restart out_count", out_count, 4'd1);
    // Pending result survives en=0 and is still delivered
    for (int k = 0; k < 3; k++) begin
      step(0, 0, 0);
      check_bit($sformatf("hold c%0d out_valid", k), out_valid, 1'b1);
      check_cnt($sformatf("hold c%0d out_count", k), out_count, 4'd1);
    end
    step(0, 0, 1);
    check_bit("hold drained out_valid", out_valid, 1'b0);
    check_bit("hold overrun sticky", overrun, 1'b1);

    // Reset mid-window while a result is pending
    step(1, 0, 0);
    for (int k = 0; k < 16; k++) step(1, (k == 3), 0);
    check_bit("prereset out_valid", out_valid, 1'b1);
    for (int k = 0; k < 5; k++) step(1, 1, 0);
    reset = 1'b1;
    step(1, 1, 0);
    check_all_zero("midreset");
    reset = 1'b0;

    // Alarm: window totals 2 then 3
    exp_q.push_back(4'd2);
    exp_q.push_back(4'd3);
    step(1, 0, 1);
    for (int w = 0; w < 2; w++) begin
      cur = exp_q.pop_front();
      for (int k = 0; k < 16; k++) begin
        if (w == 0) step(1, (k == 1 || k == 9), 1);
        else        step(1, (k == 0 || k == 7 || k == 15), 1);
        check_bit($sformatf("alarm w%0d c%0d", w, k), alarm,
                  ALARM_ON && (k == 15) && (int'(cur) >= THRESH));
      end
      check_bit($sformatf("alarm w%0d out_valid", w), out_valid, 1'b1);
      check_cnt($sformatf("alarm w%0d out_count", w), out_count, cur);
    end
    step(0, 0, 1);
    check_bit("alarm pulse end", alarm, 1'b0);
    check_bit("alarm drained out_valid", out_valid, 1'b0);
    check_bit("alarm no overrun", overrun, 1'b0);

    // ---------------- report ----------------
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule : tb_seq_hit_window_counter
